adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 118 +++++++++++
 tb/tb_adder_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing a single adder among NREQ requesters.
// One registered result slot with valid/ready handshake and one-cycle latency.
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     valor1_bus,
  input  logic [NREQ*WIDTH-1:0]     valor2_bus,
  output logic [NREQ-1:0]           gnt,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic [WIDTH-1:0]          soma,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   soma_reg, soma_next;
  logic [IDX_W-1:0]   res_id_reg, res_id_next;
  logic [IDX_W-1:0]   last_reg, last_next;

  logic [WIDTH-1:0]   op1 [NREQ];
  logic [WIDTH-1:0]   op2 [NREQ];
  logic [IDX_W-1:0]   cand [NREQ];

  logic [IDX_W-1:0]   winner;
  logic               found;
  logic               accept_open;
  logic               accept;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sum;

  // cand[k] is the k-th index visited by the round-robin search,
  // starting just after the last winner and wrapping naturally in IDX_W bits.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign op1[gi]  = valor1_bus[WIDTH*gi +: WIDTH];
      assign op2[gi]  = valor2_bus[WIDTH*gi +: WIDTH];
      assign cand[gi] = last_reg + IDX_W'(gi + 1);
    end
  endgenerate

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[cand[k]]) begin
        winner = cand[k];
        found  = 1'b1;
      end
    end
  end

  // The slot is reusable in the same cycle the consumer drains it, so a
  // continuous stream sees no bubble. rst_n gates gnt while reset is held.
  assign accept_open = (state_reg == EMPTY) || res_ready;
  assign accept      = accept_open && found && rst_n;

  // Single shared adder behind the operand mux; carry out is dropped.
  assign op_a = op1[winner];
  assign op_b = op2[winner];
  assign sum  = op_a + op_b;

  always_comb begin
    gnt = '0;
    if (accept) begin
      gnt[winner] = 1'b1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    soma_next   = soma_reg;
    res_id_next = res_id_reg;
    last_next   = last_reg;
    if (accept) begin
      state_next  = FULL;
      soma_next   = sum;
      res_id_next = winner;
      last_next   = winner;
    end else if (state_reg == FULL && res_ready) begin
      state_next  = EMPTY;
    end
  end

  // last resets to NREQ-1 so requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= EMPTY;
      soma_reg   <= '0;
      res_id_reg <= '0;
      last_reg   <= IDX_W'(NREQ - 1);
    end else begin
      state_reg  <= state_next;
      soma_reg   <= soma_next;
      res_id_reg <= res_id_next;
      last_reg   <= last_next;
    end
  end

  assign res_valid = (state_reg == FULL);
  assign busy      = res_valid;
  assign soma      = soma_reg;
  assign res_id    = res_id_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter: reset, round-robin order,
// wrap-around, backpressure, operand sampling, async reset and streaming.
module tb_adder_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] valor1_bus;
  logic [127:0] valor2_bus;
  logic [3:0]   gnt;
  logic         res_valid;
  logic         res_ready;
  logic [1:0]   res_id;
  logic [31:0]  soma;
  logic         busy;

  int checks;
  int errors;

  adder_arbiter #(.NREQ(4), .WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .valor1_bus (valor1_bus),
    .valor2_bus (valor2_bus),
    .gnt        (gnt),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_id     (res_id),
    .soma       (soma),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    valor1_bus[32*i +: 32] = a;
    valor2_bus[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 4'b1111;
    res_ready = 1'b1;
    valor1_bus = '0;
    valor2_bus = '0;
    #2;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b want %b", gnt, 4'b0000); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", res_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (soma !== 32'd0) begin errors++; $display("FAIL reset_soma got %h want 0", soma); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d want 0", res_id); end
    @(negedge clk);
    req = 4'b0000;
    rst_n = 1'b1;
    $display("reset done");
  endtask

  task automatic test_basic();
    req = 4'b0001;
    res_ready = 1'b1;
    set_ops(0, 32'd5, 32'd7);
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt got %b want %b", gnt, 4'b0001); end
    tick();
    req = 4'b0000;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", res_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy); end
    checks++; if (soma !== 32'd12) begin errors++; $display("FAIL basic_soma got %0d want 12", soma); end
    checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL basic_id got %0d want 0", res_id); end
    $display("txn basic id=%0d soma=%0d", res_id, soma);
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %b want 0", res_valid); end
    checks++; if (soma !== 32'd12) begin errors++; $display("FAIL drain_soma_hold got %0d want 12", soma); end
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g;
    logic [1:0]  exp_id;
    logic [31:0] exp_sum;
    do_reset();
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_ops(i, 32'(10 * (i + 1)), 32'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      #1;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt step %0d got %b want %b", k, gnt, exp_g); end
      if (k > 0) begin
        exp_id  = 2'((k - 1) % 4);
        exp_sum = 32'(10 * (exp_id + 1) + exp_id);
        checks++; if (res_id !== exp_id || soma !== exp_sum || res_valid !== 1'b1) begin
          errors++; $display("FAIL rr_res step %0d got id=%0d soma=%0d v=%b want id=%0d soma=%0d v=1", k, res_id, soma, res_valid, exp_id, exp_sum);
        end
      end
      tick();
      $display("txn rr id=%0d soma=%0d", res_id, soma);
    end
    req = 4'b0000;
    checks++; if (res_id !== 2'd0 || soma !== 32'd10) begin errors++; $display("FAIL rr_last got id=%0d soma=%0d want id=0 soma=10", res_id, soma); end
    tick();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b want 0", res_valid); end
  endtask

  task automatic test_overflow();
    set_ops(2, 32'hFFFF_FFFF, 32'h0000_0002);
    req = 4'b0100;
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL ovf_gnt got %b want %b", gnt, 4'b0100); end
    tick();
    req = 4'b0000;
    checks++; if (soma !== 32'h0000_0001) begin errors++; $display("FAIL ovf_soma got %h want 00000001", soma); end
    checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL ovf_id got %0d want 2", res_id); end
    $display("txn ovf id=%0d soma=%h", res_id, soma);
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    req = 4'b0010;
    set_ops(1, 32'd10, 32'd20);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL bp_gnt cycle %0d got %b want 0000", k, gnt); end
      tick();
      checks++; if (soma !== 32'd1 || res_id !== 2'd2 || res_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold cycle %0d got soma=%0d id=%0d v=%b want soma=1 id=2 v=1", k, soma, res_id, res_valid);
      end
    end
    res_ready = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL bp_release_gnt got %b want %b", gnt, 4'b0010); end
    tick();
    req = 4'b0000;
    checks++; if (soma !== 32'd30 || res_id !== 2'd1) begin errors++; $display("FAIL bp_new got soma=%0d id=%0d want soma=30 id=1", soma, res_id); end
    $display("txn bp id=%0d soma=%0d", res_id, soma);
  endtask

  task automatic test_operand_hold();
    res_ready = 1'b1;
    req = 4'b0001;
    set_ops(0, 32'd3, 32'd4);
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL hold_gnt got %b want %b", gnt, 4'b0001); end
    tick();
    set_ops(0, 32'd1000, 32'd1000);
    req = 4'b0000;
    res_ready = 1'b0;
    #1;
    checks++; if (soma !== 32'd7 || res_id !== 2'd0) begin errors++; $display("FAIL hold_soma got soma=%0d id=%0d want soma=7 id=0", soma, res_id); end
    tick();
    checks++; if (soma !== 32'd7) begin errors++; $display("FAIL hold_soma_later got %0d want 7", soma); end
    $display("txn hold id=%0d soma=%0d", res_id, soma);
  endtask

  task automatic test_async_reset();
    req = 4'b1111;
    res_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL arst_valid got v=%b busy=%b want 0 0", res_valid, busy); end
    checks++; if (soma !== 32'd0 || res_id !== 2'd0) begin errors++; $display("FAIL arst_regs got soma=%0d id=%0d want 0 0", soma, res_id); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL arst_gnt got %b want 0000", gnt); end
    #1;
    rst_n = 1'b1;
    req = 4'b0000;
    res_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL arst_idle cycle %0d got %b want 0", k, res_valid); end
    end
    req = 4'b1001;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL arst_prio got %b want %b", gnt, 4'b0001); end
    tick();
    req = 4'b0000;
    checks++; if (res_id !== 2'd0 || soma !== 32'd2000) begin errors++; $display("FAIL arst_first got id=%0d soma=%0d want id=0 soma=2000", res_id, soma); end
    $display("txn arst id=%0d soma=%0d", res_id, soma);
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_g;
    logic [1:0]  exp_id;
    logic [31:0] exp_sum;
    res_ready = 1'b1;
    set_ops(0, 32'd100, 32'd200);
    set_ops(1, 32'd1, 32'd2);
    req = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0010 : 4'b0001;
      #1;
      checks++; if (gnt !== exp_g) begin errors++; $display("FAIL b2b_gnt step %0d got %b want %b", k, gnt, exp_g); end
      tick();
      exp_id  = (k % 2 == 0) ? 2'd1 : 2'd0;
      exp_sum = (k % 2 == 0) ? 32'd3 : 32'd300;
      checks++; if (res_valid !== 1'b1 || res_id !== exp_id || soma !== exp_sum) begin
        errors++; $display("FAIL b2b_res step %0d got v=%b id=%0d soma=%0d want v=1 id=%0d soma=%0d", k, res_valid, res_id, soma, exp_id, exp_sum);
      end
      $display("txn b2b id=%0d soma=%0d", res_id, soma);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_overflow();
    test_backpressure();
    test_operand_hold();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
